// File: rtl/updown_mod_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: direction
// constants, a clog2 helper and the MODULUS legality check.
package cnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // WIDTH in 1..16, MODULUS in 2..2^WIDTH.
    function automatic bit modulus_ok(input int w, input int m);
        return (w >= 1) && (w <= 16) && (m >= 2) && (clog2(m) <= w);
    endfunction

endpackage

// File: rtl/updown_mod_counter_toggle_cell.sv
// One bit of the counter: synchronous-clear toggle stage.
// Ports: clk, reset (sync, active-high), toggle (invert q), q (state).
module toggle_cell (
    input  logic clk,
    input  logic reset,
    input  logic toggle,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= 1'b0;
        else if (toggle)
            q <= ~q;
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH toggle cells, with
// clamped parallel load, combinational terminal count and a registered
// wrap pulse.
// Ports: clk, reset (sync, active-high), enable, up, load, load_val,
//        count (registered), tc (combinational), wrap (registered).
// Optional macro CNT_POWERON_CLEAR_EN: the first clk edge acts as reset.
module updown_mod_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("updown_mod_counter: illegal WIDTH/MODULUS");
    end

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic             clr;
    logic [WIDTH-1:0] nxt;
    logic             wrap_nxt;

`ifdef CNT_POWERON_CLEAR_EN
    // Configuration-time value gives a defined state with no reset pin.
    logic first_run = 1'b1;

    always_ff @(posedge clk) begin
        first_run <= 1'b0;
    end

    assign clr = reset | first_run;
`else
    assign clr = reset;
`endif

    always_comb begin
        nxt      = count;
        wrap_nxt = 1'b0;
        if (load) begin
            nxt = (load_val > TOP) ? TOP : load_val;
        end else if (enable) begin
            if (up == DIR_UP) begin
                if (count == TOP) begin
                    nxt      = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    nxt      = TOP;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = count - 1'b1;
                end
            end
        end
    end

    // Same-cycle carry so a cascaded digit steps with zero latency.
    assign tc = enable & ((up & (count == TOP)) | (~up & (count == '0)));

    always_ff @(posedge clk) begin
        if (clr)
            wrap <= 1'b0;
        else
            wrap <= wrap_nxt;
    end

    // Each cell flips exactly where the next state differs.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        toggle_cell u_cell (
            .clk    (clk),
            .reset  (clr),
            .toggle (count[i] ^ nxt[i]),
            .q      (count[i])
        );
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: mod-10, mod-8 (full binary)
// and a two-digit mod-10 cascade against an arithmetic reference model.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset, enable, up, load, c_en;
    logic [3:0] load_val;

    logic [3:0] count_a;
    logic       tc_a, wrap_a;
    logic [2:0] count_b;
    logic       tc_b, wrap_b;
    logic [3:0] u_count, t_count;
    logic       u_tc, u_wrap, t_tc, t_wrap;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up(up),
        .load(load), .load_val(load_val),
        .count(count_a), .tc(tc_a), .wrap(wrap_a)
    );

    updown_mod_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .up(up),
        .load(load), .load_val(load_val[2:0]),
        .count(count_b), .tc(tc_b), .wrap(wrap_b)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) units (
        .clk(clk), .reset(reset), .enable(c_en), .up(1'b1),
        .load(1'b0), .load_val(4'd0),
        .count(u_count), .tc(u_tc), .wrap(u_wrap)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) tens (
        .clk(clk), .reset(reset), .enable(u_tc), .up(1'b1),
        .load(1'b0), .load_val(4'd0),
        .count(t_count), .tc(t_tc), .wrap(t_wrap)
    );

    typedef struct {
        int c;
        bit w;
    } ms_t;

    typedef struct {
        bit tca, tcb;
        int ca, cb;
        bit wa, wb;
        int cas;
        bit twr;
    } exp_t;

    exp_t q[$];
    ms_t  sa, sb, sc;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic ms_t mstep(int m, ms_t s, bit r, bit ld, int lv,
                                  bit en, bit u);
        ms_t n;
        n.c = s.c;
        n.w = 1'b0;
        if (r) begin
            n.c = 0;
        end else if (ld) begin
            n.c = (lv < m) ? lv : m - 1;
        end else if (en) begin
            if (u) begin
                n.w = (s.c == m - 1);
                n.c = (s.c + 1) % m;
            end else begin
                n.w = (s.c == 0);
                n.c = (s.c + m - 1) % m;
            end
        end
        return n;
    endfunction

    function automatic bit mtc(int m, ms_t s, bit en, bit u);
        return en && ((u && s.c == m - 1) || (!u && s.c == 0));
    endfunction

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, bit ld, int lv, bit en, bit u, bit cen);
        exp_t e;
        @(negedge clk);
        reset    = r;
        load     = ld;
        load_val = 4'(lv);
        enable   = en;
        up       = u;
        c_en     = cen;
        e.tca = mtc(10, sa, en, u);
        e.tcb = mtc(8, sb, en, u);
        sa = mstep(10, sa, r, ld, lv, en, u);
        sb = mstep(8, sb, r, ld, lv & 7, en, u);
        sc = mstep(100, sc, r, 1'b0, 0, cen, 1'b1);
        e.ca  = sa.c;
        e.wa  = sa.w;
        e.cb  = sb.c;
        e.wb  = sb.w;
        e.cas = sc.c;
        e.twr = sc.w;
        q.push_back(e);
    endtask

    // Monitor: tc before the edge, registered outputs after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q[0];
                chk("tc_a", int'(tc_a), int'(e.tca));
                chk("tc_b", int'(tc_b), int'(e.tcb));
                @(posedge clk);
                #1;
                e = q.pop_front();
                chk("count_a", int'(count_a), e.ca);
                chk("wrap_a", int'(wrap_a), int'(e.wa));
                chk("count_b", int'(count_b), e.cb);
                chk("wrap_b", int'(wrap_b), int'(e.wb));
                chk("cascade", int'(t_count) * 10 + int'(u_count), e.cas);
                chk("tens_wrap", int'(t_wrap), int'(e.twr));
            end
        end
    end

    initial begin
        bit up_t;
        reset = 1'b0; load = 1'b0; load_val = 4'd0;
        enable = 1'b0; up = 1'b1; c_en = 1'b0;
        sa = '{0, 1'b0};
        sb = '{0, 1'b0};
        sc = '{0, 1'b0};

        repeat (2) drive(1, 0, 0, 0, 1, 0);
        repeat (12) drive(0, 0, 0, 1, 1, 1);
        drive(0, 1, 2, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 1, 0, 1);
        drive(0, 1, 13, 1, 1, 1);
        drive(1, 1, 5, 1, 1, 1);
        drive(0, 1, 5, 0, 1, 1);
        repeat (3) drive(0, 0, 0, 0, 1, 1);
        up_t = 1'b1;
        repeat (4) begin
            drive(0, 0, 0, 1, up_t, 1);
            up_t = ~up_t;
        end
        repeat (110) drive(0, 0, 0, 0, 1, 1);

        repeat (400) begin
            drive($urandom_range(0, 31) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15),
                  $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)),
                  1'b1);
        end

        @(posedge clk);
        #3;
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
